// File: rtl/accum_burst_ctrl.sv
// Accumulator burst write controller.
// Launches a burst of cfg_len beats starting at cfg_base. In load mode each
// beat is fetched from the s_* stream, then issued on the write-command and
// write-data channels. In clear mode all-zero beats are issued back to back.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   start, cfg_*              burst launch and configuration (latched in IDLE)
//   s_valid/s_ready/s_data    input beat stream
//   wr_valid/wr_ready, wr_addr, wr_mask, wr_zone_id, accum_en   write command
//   wvalid/wready, wdata      write data
//   busy, done                burst status
module accum_burst_ctrl #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ZONE_WIDTH = 2,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic                            cfg_clear,
  input  logic [ZONE_WIDTH-1:0]           cfg_zone,
  input  logic [ADDR_WIDTH-1:0]           cfg_base,
  input  logic [LEN_WIDTH-1:0]            cfg_len,
  input  logic [NUM_BANKS-1:0]            cfg_mask,
  input  logic                            cfg_accum,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] s_data,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [NUM_BANKS-1:0]            wr_mask,
  output logic [ZONE_WIDTH-1:0]           wr_zone_id,
  output logic                            accum_en,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned BUS_W = NUM_BANKS * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  state_t                state;
  logic                  clear_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_idx;

  logic [LEN_WIDTH-1:0]  next_idx_c;
  logic [ADDR_WIDTH-1:0] next_addr_c;
  logic                  beat_done_c;

  // A channel counts as finished once its valid has dropped or is being accepted now.
  assign next_idx_c  = beat_idx + LEN_WIDTH'(1);
  assign next_addr_c = base_q + ADDR_WIDTH'(next_idx_c);
  assign beat_done_c = (!wr_valid || wr_ready) && (!wvalid || wready);

  // Burst FSM with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      clear_q    <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      beat_idx   <= '0;
      s_ready    <= 1'b0;
      wr_valid   <= 1'b0;
      wvalid     <= 1'b0;
      wr_addr    <= '0;
      wr_mask    <= '0;
      wr_zone_id <= '0;
      accum_en   <= 1'b0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            clear_q    <= cfg_clear;
            base_q     <= cfg_base;
            len_q      <= cfg_len;
            wr_mask    <= cfg_mask;
            wr_zone_id <= cfg_zone;
            accum_en   <= cfg_accum;
            beat_idx   <= '0;
            wr_addr    <= cfg_base;
            busy       <= 1'b1;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!cfg_clear) begin
              state   <= FETCH;
              s_ready <= 1'b1;
            end else begin
              state    <= ISSUE;
              wdata    <= BUS_W'(0);
              wr_valid <= 1'b1;
              wvalid   <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (s_valid && s_ready) begin
            wdata    <= s_data;
            s_ready  <= 1'b0;
            wr_valid <= 1'b1;
            wvalid   <= 1'b1;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          // Each channel retires on its own handshake.
          if (wr_valid && wr_ready) wr_valid <= 1'b0;
          if (wvalid && wready)     wvalid   <= 1'b0;
          if (beat_done_c) begin
            beat_idx <= next_idx_c;
            wr_addr  <= next_addr_c;
            if (next_idx_c == len_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (clear_q) begin
              // Back-to-back zero beats: re-arm both channels immediately.
              wr_valid <= 1'b1;
              wvalid   <= 1'b1;
            end else begin
              state   <= FETCH;
              s_ready <= 1'b1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/accum_burst_ctrl.md
ACCUM_BURST_CTRL -- requirements
Module: accum_burst_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 4: banks per accumulator word.
REQ-002 Parameter ADDR_WIDTH, default 9: bank address width.
REQ-003 Parameter DATA_WIDTH, default 64: data width per bank.
REQ-004 Parameter ZONE_WIDTH, default 2: zone ID width.
REQ-005 Parameter LEN_WIDTH, default 10: burst length field width.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle burst launch, sampled in IDLE only.
REQ-009 cfg_clear  in  1  1 = write zeros, no stream; 0 = stream load.
REQ-010 cfg_zone  in  ZONE_WIDTH  target zone.
REQ-011 cfg_base  in  ADDR_WIDTH  first address.
REQ-012 cfg_len  in  LEN_WIDTH  beat count; 0 = empty burst.
REQ-013 cfg_mask  in  NUM_BANKS  bank write mask for every beat.
REQ-014 cfg_accum  in  1  accumulate enable for every beat.
REQ-015 s_valid / s_ready  in / out  1  input stream handshake.
REQ-016 s_data  in  NUM_BANKS*DATA_WIDTH  stream beat, bank b at bits [b*DATA_WIDTH +: DATA_WIDTH].
REQ-017 wr_valid / wr_ready  out / in  1  write-command handshake to the routed port.
REQ-018 wr_addr, wr_mask, wr_zone_id, accum_en  out  ADDR_WIDTH, NUM_BANKS, ZONE_WIDTH, 1  write-command fields.
REQ-019 wvalid / wready  out / in  1  write-data handshake.
REQ-020 wdata  out  NUM_BANKS*DATA_WIDTH  write data, same bank packing as s_data.
REQ-021 busy  out  1  high from start acceptance until DONE exits.
REQ-022 done  out  1  one-cycle pulse at burst end.

Function
REQ-023 The FSM SHALL have states IDLE, FETCH, ISSUE, DONE.
REQ-024 IDLE + start SHALL latch all cfg_* fields; next state is DONE when cfg_len==0, else FETCH when cfg_clear==0, else ISSUE.
REQ-025 Start SHALL be ignored outside IDLE, and cfg_* SHALL be ignored after latching.
REQ-026 In FETCH, s_ready SHALL be 1; on s_valid&s_ready, s_data SHALL be registered and the FSM SHALL go to ISSUE.
REQ-027 s_ready SHALL be 0 in all other states and always 0 in clear mode.
REQ-028 On ISSUE entry, wr_valid and wvalid SHALL assert together from registers; wdata SHALL be the latched beat, or all-zero in clear mode.
REQ-029 wr_addr SHALL equal (cfg_base + beat_index) mod 2^ADDR_WIDTH, so addresses wrap 511->0 at default width.
REQ-030 wr_mask, wr_zone_id and accum_en SHALL carry the latched cfg_mask, cfg_zone and cfg_accum.
REQ-031 The command and data channels SHALL complete independently: wr_valid drops the cycle after wr_valid&wr_ready, wvalid drops the cycle after wvalid&wready, and the other channel keeps waiting.
REQ-032 Payload SHALL stay stable while valid is high and not yet accepted.
REQ-033 A beat SHALL complete when both channels are accepted, including acceptance in the same cycle or in different cycles.
REQ-034 On beat completion, beat_index SHALL increment; if beat_index+1==cfg_len the FSM SHALL go to DONE, else to FETCH (load) or stay in ISSUE with fresh valids next cycle (clear).
REQ-035 For a ready-always-1 target, throughput SHALL be one beat per 2 cycles in load mode and 1 beat per cycle in clear mode.
REQ-036 DONE SHALL last one cycle with done=1, busy=1, then return to IDLE with busy=0.
REQ-037 Accepted beats SHALL never be duplicated or dropped, and at most one beat SHALL be outstanding.

Reset
REQ-038 While rstn=0, the block SHALL force: FSM IDLE; beat_index 0; wr_valid, wvalid, s_ready, busy, done 0; wr_addr, wr_mask, wr_zone_id, accum_en, wdata 0.
REQ-039 Reset asserted mid-burst SHALL abort the burst immediately without a done pulse; after release the block SHALL accept a new start.

Verification
REQ-040 Clear, zone 2, base 0x030, len 4, mask 4'hF, both ready tied 1 -> wr_addr 0x030..0x033 on 4 consecutive cycles, wdata 0, then done pulse, busy low.
REQ-041 Load, zone 1, base 0x020, len 2, stream A0..0, B0..0 -> addr 0x020 gets A0..0 and 0x021 gets B0..0; s_ready is high only in FETCH.
REQ-042 wr_ready held 0 for 3 cycles while wready=1 -> wvalid drops after 1 cycle, wr_valid holds with stable fields, and the beat completes on the first wr_ready.
REQ-043 base 0x1FE, len 3, clear -> addresses 0x1FE, 0x1FF, 0x000.
REQ-044 start with len 0 -> no valid asserted, done exactly one cycle after start; start during busy -> ignored, and the beat count is unchanged.
REQ-045 rstn pulled low during the 2nd beat of len 4 -> all outputs 0 asynchronously and no done; a new len-1 burst after release completes normally.
